// File: rtl/hessian_pkg.sv
// Shared types and helpers for the multi-scale Hessian scheduler.
// Optional watchdog is enabled by defining HESSIAN_SCHED_TIMEOUT_EN.
package hessian_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_NEXT,
        S_DONE
    } sched_state_t;

    localparam int ROI_SIZE_DEF = 470;
    localparam int NPC_DEF      = 2;
    localparam int KSIZE_DEF    = 5;
    localparam int KNUM_DEF     = 3;
    localparam int KDW_DEF      = 12;

    localparam int BEATS  = ROI_SIZE_DEF * ROI_SIZE_DEF / NPC_DEF;
    localparam int KSET_W = KNUM_DEF * KSIZE_DEF * KSIZE_DEF * KDW_DEF;

    typedef logic [KSET_W-1:0] kernel_set_t;

    function automatic int calc_beats(input int roi, input int npc);
        return roi * roi / npc;
    endfunction

    function automatic int kset_lsb(input int scale, input int kset_w);
        return scale * kset_w;
    endfunction

endpackage

// File: rtl/sched_prefetch_fifo.sv
// Two-entry prefetch FIFO between the frame-memory read port and the engine.
// An empty FIFO passes a same-cycle push straight through to its head.
module sched_prefetch_fifo #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         head_valid,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         empty;
    logic         store;
    logic         remove;

    always_comb begin
        empty      = (cnt == 2'd0);
        store      = push && !(empty && pop);
        remove     = pop && !empty;
        head_valid = !empty || push;
        head       = empty ? din : mem[rd_ptr];
        occ        = cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            cnt    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (remove) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, store} - {1'b0, remove};
        end
    end

endmodule

// File: rtl/hessian_scale_sched.sv
// Per-frame scheduler running the Hessian engine once per kernel scale.
// Define HESSIAN_SCHED_TIMEOUT_EN to enable the RUN-state watchdog.
module hessian_scale_sched
    import hessian_pkg::*;
#(
    parameter int ROI_SIZE          = 470,
    parameter int NUM_PER_CYCLE     = 2,
    parameter int IN_WIDTH          = 12,
    parameter int KERNEL_SIZE       = 5,
    parameter int KERNEL_NUM        = 3,
    parameter int KERNEL_DATA_WIDTH = 12,
    parameter int NUM_SCALES        = 4,
    parameter int OUT_WIDTH         = 28,
    parameter int ADDR_W            = 20,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic [ADDR_W-1:0] roi_base,
    input  logic [NUM_SCALES*KERNEL_NUM*KERNEL_SIZE*KERNEL_SIZE*KERNEL_DATA_WIDTH-1:0] kernel_bank,
    output logic mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [NUM_PER_CYCLE*IN_WIDTH-1:0] mem_rd_data,
    output logic eng_rst_n,
    output logic eng_clk_en,
    output logic [NUM_PER_CYCLE*IN_WIDTH-1:0] eng_din,
    output logic [KERNEL_NUM*KERNEL_SIZE*KERNEL_SIZE*KERNEL_DATA_WIDTH-1:0] eng_kernel,
    input  logic eng_valid,
    input  logic [NUM_PER_CYCLE*OUT_WIDTH-1:0] eng_dout,
    output logic res_valid,
    input  logic res_ready,
    output logic [NUM_PER_CYCLE*OUT_WIDTH-1:0] res_data,
    output logic [$clog2(NUM_SCALES)-1:0] res_scale,
    output logic [$clog2(ROI_SIZE)-1:0] res_row,
    output logic [$clog2(ROI_SIZE)-1:0] res_col,
    output logic res_last,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int NBEATS = calc_beats(ROI_SIZE, NUM_PER_CYCLE);
    localparam int DW     = NUM_PER_CYCLE * IN_WIDTH;
    localparam int KW     = KERNEL_NUM * KERNEL_SIZE * KERNEL_SIZE * KERNEL_DATA_WIDTH;
    localparam int IW     = $clog2(NBEATS + 1);
    localparam int SW     = $clog2(NUM_SCALES);
    localparam int RW     = $clog2(ROI_SIZE);

    sched_state_t      state;
    sched_state_t      state_n;
    logic              load_ph;
    logic              load_ph_n;
    logic [SW-1:0]     scale;
    logic [ADDR_W-1:0] base_q;
    logic [IW-1:0]     in_idx;
    logic [IW-1:0]     out_cnt;
    logic [RW-1:0]     row;
    logic [RW-1:0]     col;
    logic              rd_pend;
    logic [KW-1:0]     kern_q;
    logic [KW-1:0]     kset [NUM_SCALES];

    logic              flush;
    logic              head_valid;
    logic [DW-1:0]     head;
    logic [1:0]        occ;

    logic is_run;
    logic load1;
    logic load2;
    logic stop;
    logic in_left;
    logic rd_ok;
    logic exhausted;
    logic input_ok;
    logic xfer;
    logic last_beat;
    logic last_scale;
    logic tmo_hit;

    for (genvar g = 0; g < NUM_SCALES; g++) begin : g_kset
        assign kset[g] = kernel_bank[kset_lsb(g, KW) +: KW];
    end

    sched_prefetch_fifo #(
        .W(DW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (rd_pend),
        .din       (mem_rd_data),
        .pop       (eng_clk_en),
        .head_valid(head_valid),
        .head      (head),
        .occ       (occ)
    );

`ifdef HESSIAN_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Only cycles where the consumer is ready count toward a stall.
    always_ff @(posedge clk) begin
        if (!rst_n || state != S_RUN) begin
            tmo_cnt <= '0;
        end else if (xfer) begin
            tmo_cnt <= '0;
        end else if (res_ready) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign tmo_hit = (state == S_RUN) && (tmo_cnt == TW'(TIMEOUT_CYCLES));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        is_run     = (state == S_RUN);
        load1      = (state == S_LOAD) && !load_ph;
        load2      = (state == S_LOAD) && load_ph;
        stop       = (abort && state != S_IDLE) || tmo_hit;
        in_left    = in_idx < IW'(NBEATS);
        rd_ok      = (occ == 2'd0) || (occ == 2'd1 && !rd_pend);
        mem_rd_en  = (is_run || load2) && in_left && rd_ok && !stop;
        mem_rd_addr = mem_rd_en ? base_q + ADDR_W'(in_idx) : '0;
        // A read still in flight means the ROI is not yet drained.
        exhausted  = !in_left && occ == 2'd0 && !rd_pend;
        input_ok   = head_valid || exhausted;
        eng_clk_en = is_run && res_ready && input_ok;
        eng_din    = head_valid ? head : '0;
        res_valid  = is_run && eng_valid && input_ok;
        xfer       = res_valid && res_ready;
        last_beat  = (out_cnt == IW'(NBEATS - 1));
        last_scale = (scale == SW'(NUM_SCALES - 1));
        res_last   = res_valid && last_beat && last_scale;
        flush      = load1 || stop;
        eng_rst_n  = load2 || state == S_RUN || state == S_NEXT || state == S_DONE;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        err        = tmo_hit;
        res_data   = eng_dout;
        res_scale  = scale;
        res_row    = row;
        res_col    = col;
        eng_kernel = kern_q;
    end

    always_comb begin
        state_n   = state;
        load_ph_n = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_n = S_LOAD;
            S_LOAD: begin
                if (!load_ph) load_ph_n = 1'b1;
                else state_n = S_RUN;
            end
            S_RUN:  if (xfer && last_beat) state_n = S_NEXT;
            S_NEXT: state_n = last_scale ? S_DONE : S_LOAD;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (stop) begin
            state_n   = S_IDLE;
            load_ph_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            load_ph <= 1'b0;
        end else begin
            state   <= state_n;
            load_ph <= load_ph_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scale   <= '0;
            base_q  <= '0;
            in_idx  <= '0;
            out_cnt <= '0;
            row     <= '0;
            col     <= '0;
            rd_pend <= 1'b0;
            kern_q  <= '0;
        end else begin
            rd_pend <= mem_rd_en;
            if (state == S_IDLE && start) begin
                base_q <= roi_base;
                scale  <= '0;
            end
            if (load1) begin
                kern_q  <= kset[scale];
                in_idx  <= '0;
                out_cnt <= '0;
                row     <= '0;
                col     <= '0;
            end
            if (mem_rd_en) begin
                in_idx <= in_idx + IW'(1);
            end
            if (xfer) begin
                out_cnt <= out_cnt + IW'(1);
                if (col == RW'(ROI_SIZE - NUM_PER_CYCLE)) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + RW'(NUM_PER_CYCLE);
                end
            end
            if (state == S_NEXT && !last_scale && !stop) begin
                scale <= scale + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hessian_scale_sched.sv
// Directed bench for hessian_scale_sched on an 8x8 ROI with two scales.
// Watchdog checks follow HESSIAN_SCHED_TIMEOUT_EN.
module tb_hessian_scale_sched;

    localparam int ROI = 8;
    localparam int NPC = 2;
    localparam int NS  = 2;
    localparam int AW  = 20;
    localparam int KW  = 900;
    localparam int TMO = 64;
    localparam int NB  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort, res_ready;
    logic [AW-1:0] roi_base, cur_base;
    logic [NS*KW-1:0] kernel_bank;
    logic mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [23:0] mem_rd_data;
    logic eng_rst_n, eng_clk_en;
    logic [23:0] eng_din;
    logic [KW-1:0] eng_kernel;
    logic eng_valid;
    logic [55:0] eng_dout;
    logic res_valid, res_last, busy, done, err;
    logic [55:0] res_data;
    logic [0:0] res_scale;
    logic [2:0] res_row, res_col;

    hessian_scale_sched #(
        .ROI_SIZE(ROI), .NUM_PER_CYCLE(NPC), .IN_WIDTH(12),
        .KERNEL_SIZE(5), .KERNEL_NUM(3), .KERNEL_DATA_WIDTH(12),
        .NUM_SCALES(NS), .OUT_WIDTH(28), .ADDR_W(AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .roi_base(roi_base), .kernel_bank(kernel_bank),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .eng_rst_n(eng_rst_n), .eng_clk_en(eng_clk_en),
        .eng_din(eng_din), .eng_kernel(eng_kernel),
        .eng_valid(eng_valid), .eng_dout(eng_dout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_scale(res_scale),
        .res_row(res_row), .res_col(res_col), .res_last(res_last),
        .busy(busy), .done(done), .err(err)
    );

    logic [23:0] mem_words [NB];
    logic [KW-1:0] ks0, ks1;
    int total = 0;
    int passed = 0;

    function automatic logic [KW-1:0] ks(input int s);
        return (s == 0) ? {75{12'h111}} : {75{12'h222}};
    endfunction

    function automatic logic [55:0] eng_f(input logic [23:0] d, input logic [7:0] k);
        logic [11:0] p0, p1;
        p0 = d[11:0];
        p1 = d[23:12];
        return {28'(p1) + 28'(k), 28'(p0) + 28'(k)};
    endfunction

    // Frame memory: fixed one-cycle read latency
    always @(posedge clk)
        mem_rd_data <= mem_rd_en ? mem_words[5'(mem_rd_addr - cur_base)] : 24'h0;

    // Engine model: two-stage pipeline advancing only on eng_clk_en
    logic [1:0] ev = 2'b00;
    logic [55:0] ed1, ed2;
    logic eng_mute = 1'b0;
    always @(posedge clk) begin
        if (!eng_rst_n) ev <= 2'b00;
        else if (eng_clk_en) begin
            ev  <= {ev[0], 1'b1};
            ed1 <= eng_f(eng_din, eng_kernel[7:0]);
            ed2 <= ed1;
        end
    end
    assign eng_valid = ev[1] & ~eng_mute;
    assign eng_dout  = ed2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic with_abort);
        @(negedge clk);
        roi_base  = base;
        cur_base  = base;
        start     = 1'b1;
        abort     = with_abort;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("load1_busy", busy, 1);
        chk("load1_eng_rst", eng_rst_n, 0);
        chk("load1_no_rd", mem_rd_en, 0);
        @(posedge clk);
    endtask

    task automatic stream(input bit rnd, input int ab_s, input int ab_b);
        int sc = 0, beat = 0, dk = 0, rk = 0, last_cyc = -100;
        bit fin = 0;
        for (int cyc = 0; cyc < 1500 && !fin; cyc++) begin
            @(negedge clk);
            res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (cyc == 20);
            abort = (ab_s == sc && ab_b == beat);
            #1;
            if (cyc == 0) chk("first_rd", mem_rd_en, 1);
            if (busy && !eng_rst_n) rk = 0;
            if (mem_rd_en) begin
                chk("rd_addr", mem_rd_addr, AW'(cur_base + rk));
                rk++;
            end
            if (!res_ready) chk("clk_en_hold", eng_clk_en, 0);
            if (eng_clk_en) begin
                chk("din", eng_din, dk < NB ? mem_words[dk] : 24'h0);
                chk("kernel", eng_kernel === ks(sc), 1);
                dk++;
            end
            if (res_valid && res_ready) begin
                chk("data", res_data, eng_f(mem_words[beat], sc == 0 ? 8'h11 : 8'h22));
                chk("scale", res_scale, sc);
                chk("row", res_row, beat / 4);
                chk("col", res_col, (beat % 4) * 2);
                chk("last", res_last, (sc == NS - 1 && beat == NB - 1));
                beat++;
                if (beat == NB) begin
                    if (sc == NS - 1) last_cyc = cyc;
                    sc++;
                    beat = 0;
                    dk = 0;
                end
            end
            if (done) begin
                chk("done_lat", cyc - last_cyc, 2);
                fin = 1;
            end
            if (abort) begin
                @(posedge clk);
                #1;
                abort = 1'b0;
                start = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_eng_rst", eng_rst_n, 0);
                chk("abort_rv", res_valid, 0);
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    chk("abort_no_done", done, 0);
                    chk("abort_idle", busy, 0);
                end
                return;
            end
        end
        start = 1'b0;
        chk("stream_done", fin, 1);
        @(negedge clk);
        #1;
        chk("busy_drop", busy, 0);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        res_ready = 1'b0;
        roi_base = '0;
        cur_base = '0;
        ks0 = ks(0);
        ks1 = ks(1);
        kernel_bank = {ks1, ks0};
        for (int i = 0; i < NB; i++) mem_words[i] = 24'($urandom);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_eng_rst", eng_rst_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_rd_addr", mem_rd_addr, 0);
        chk("rst_clk_en", eng_clk_en, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_kernel", eng_kernel === '0, 1);
        chk("rst_din", eng_din, 0);

        @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("idle_abort", busy, 0);

        do_start(20'h00100, 1'b0);
        stream(1'b0, -1, -1);

        do_start(20'h00100, 1'b1);
        stream(1'b1, -1, -1);

        do_start(20'h00100, 1'b0);
        stream(1'b0, 1, 10);

        do_start(20'hFFFF0, 1'b0);
        stream(1'b1, -1, -1);

        do_start(20'h00100, 1'b0);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_eng_rst", eng_rst_n, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd_en", mem_rd_en, 0);
        chk("mid_rst_clk_en", eng_clk_en, 0);
        chk("mid_rst_rv", res_valid, 0);
        chk("mid_rst_row", res_row, 0);
        chk("mid_rst_col", res_col, 0);
        chk("mid_rst_din", eng_din, 0);
        chk("mid_rst_kernel", eng_kernel === '0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        eng_mute = 1'b1;
        do_start(20'h00100, 1'b0);
`ifdef HESSIAN_SCHED_TIMEOUT_EN
        begin
            int hit = -1;
            for (int i = 2; i < 300 && hit < 0; i++) begin
                @(negedge clk);
                #1;
                if (err) hit = i;
            end
            chk("tmo_cycle", hit, 67);
            @(negedge clk);
            #1;
            chk("tmo_idle", busy, 0);
            chk("tmo_err_pulse", err, 0);
            chk("tmo_no_done", done, 0);
        end
`else
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            chk("no_tmo_err", err, 0);
        end
        chk("no_tmo_busy", busy, 1);
        chk("no_tmo_rv", res_valid, 0);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("no_tmo_abort", busy, 0);
`endif
        eng_mute = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
